// File: rtl/word_demux4_pkg.sv
// Shared constants for the 1-to-4 word demultiplexer and its holding slots.
package word_demux4_pkg;
  localparam int WORD_W = 16;
  localparam int N_OUT  = 4;
  localparam int SEL_W  = 2;
  localparam logic [WORD_W-1:0] RST_DATA = 16'h0000;
endpackage

// File: rtl/demux_slot.sv
// Single-entry holding register with its own valid bit; a load wins over a drain.
module demux_slot #(
  parameter int W = word_demux4_pkg::WORD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         drain,
  input  logic [0:W-1] load_data,
  output logic         valid,
  output logic [0:W-1] data
);
  import word_demux4_pkg::*;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= W'(RST_DATA);
    end else if (load) begin
      // Covers drain-and-reload: old word leaves, new word lands, no bubble.
      valid <= 1'b1;
      data  <= load_data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/word_demux4.sv
// Registered 1-to-4 word demultiplexer: steers one producer word into one of
// four single-entry output channels, each with its own valid/ready handshake.
module word_demux4 #(
  parameter int WORD_W = word_demux4_pkg::WORD_W,
  parameter int N_OUT  = word_demux4_pkg::N_OUT
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [0:word_demux4_pkg::SEL_W-1] i_sel,
  input  logic [0:WORD_W-1]                 i_data,
  output logic [0:N_OUT-1]                  o_valid,
  input  logic [0:N_OUT-1]                  i_ready,
  output logic [0:WORD_W-1]                 o_data0,
  output logic [0:WORD_W-1]                 o_data1,
  output logic [0:WORD_W-1]                 o_data2,
  output logic [0:WORD_W-1]                 o_data3,
  output logic                              o_busy
);
  import word_demux4_pkg::*;

  logic [0:N_OUT-1]  load;
  logic [0:N_OUT-1]  slot_valid;
  logic [0:WORD_W-1] slot_data [N_OUT];
  logic              accept;

  // Ready looks only at the addressed slot, so a stuck consumer blocks only
  // producers aimed at it; it never depends on i_valid.
  assign o_ready = !slot_valid[i_sel] || i_ready[i_sel];
  assign accept  = i_valid && o_ready;

  generate
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_slot
      assign load[gi] = accept && (i_sel == SEL_W'(gi));

      demux_slot #(.W(WORD_W)) u_slot (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .load      (load[gi]),
        .drain     (i_ready[gi]),
        .load_data (i_data),
        .valid     (slot_valid[gi]),
        .data      (slot_data[gi])
      );
    end
  endgenerate

  assign o_valid = slot_valid;
  assign o_busy  = |slot_valid;
  assign o_data0 = slot_data[0];
  assign o_data1 = slot_data[1];
  assign o_data2 = slot_data[2];
  assign o_data3 = slot_data[3];
endmodule

// File: tb/tb_word_demux4.sv
// Scoreboard bench for word_demux4: per-channel expected queues plus a slot model.
module tb_word_demux4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready;
  logic [0:1]  sel = 2'd0;
  logic [0:15] in_data = 16'h0;
  logic [0:3]  out_valid;
  logic [0:3]  in_ready = 4'b0;
  logic [0:15] d0, d1, d2, d3;
  logic        busy;

  int n_checks = 0;
  int n_err = 0;

  logic [0:3]  mv;
  logic [15:0] md [4];
  logic [15:0] q [4][$];
  logic [15:0] od [4];

  assign od[0] = d0;
  assign od[1] = d1;
  assign od[2] = d2;
  assign od[3] = d3;

  always #5 clk = ~clk;

  word_demux4 dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (in_valid),
    .o_ready (out_ready),
    .i_sel   (sel),
    .i_data  (in_data),
    .o_valid (out_valid),
    .i_ready (in_ready),
    .o_data0 (d0),
    .o_data1 (d1),
    .o_data2 (d2),
    .o_data3 (d3),
    .o_busy  (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mv = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      md[k] = 16'h0000;
      q[k].delete();
    end
  endtask

  task automatic check_reset_state();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(out_ready), 32'h1);
    for (int k = 0; k < 4; k++) chk($sformatf("rst_data%0d", k), 32'(od[k]), 32'h0);
  endtask

  // One clock: drive at posedge+1, check at negedge, update the model at posedge.
  task automatic cycle(input logic v, input logic [1:0] s, input logic [15:0] d,
                       input logic [0:3] r);
    logic       exp_ready;
    logic       acc;
    logic [15:0] w;
    in_valid = v;
    sel      = s;
    in_data  = d;
    in_ready = r;
    exp_ready = !mv[s] || r[s];
    acc = v && exp_ready;
    @(negedge clk);
    chk("ready", 32'(out_ready), 32'(exp_ready));
    chk("valid", 32'(out_valid), 32'(mv));
    chk("busy", 32'(busy), 32'(|mv));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("hold%0d", k), 32'(od[k]), 32'(md[k]));
      if (mv[k] && r[k]) begin
        if (q[k].size() == 0) begin
          chk($sformatf("sb_empty%0d", k), 32'h1, 32'h0);
        end else begin
          w = q[k].pop_front();
          chk($sformatf("drain%0d", k), 32'(od[k]), 32'(w));
        end
      end
    end
    $display("cyc v=%0b sel=%0d data=%h rdy=%b -> ready=%0b acc=%0b valid=%b",
             v, s, d, r, out_ready, acc, out_valid);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (acc && s == 2'(k)) begin
        mv[k] = 1'b1;
        md[k] = d;
        q[k].push_back(d);
      end else if (mv[k] && r[k]) begin
        mv[k] = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    model_reset();
    #2;
    check_reset_state();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic steer into channel 2, then confirm only channel 2 moved.
    cycle(1'b1, 2'd2, 16'hBEEF, 4'b0000);
    cycle(1'b0, 2'd0, 16'h0000, 4'b0000);
    chk("steer_valid", 32'(out_valid), 32'h2);
    chk("steer_data2", 32'(d2), 32'hBEEF);

    // Backpressure on the full channel 2, then redirect to channel 1.
    cycle(1'b1, 2'd2, 16'hCAFE, 4'b0000);
    cycle(1'b1, 2'd1, 16'hCAFE, 4'b0000);

    // Same-channel drain-and-load on channel 0.
    cycle(1'b1, 2'd0, 16'h1111, 4'b0000);
    cycle(1'b1, 2'd0, 16'h2222, 4'b1000);
    cycle(1'b1, 2'd3, 16'h3333, 4'b0000);
    chk("pass_data0", 32'(d0), 32'h2222);
    chk("all_full", 32'(out_valid), 32'hF);

    // Parallel drain of all four channels.
    cycle(1'b0, 2'd0, 16'h0000, 4'b1111);
    cycle(1'b0, 2'd0, 16'h0000, 4'b0000);
    chk("drained_busy", 32'(busy), 32'h0);

    // Round-robin streaming with all consumers ready.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 2'((i - 1) % 4), 16'(i), 4'b1111);
    cycle(1'b0, 2'd0, 16'h0000, 4'b1111);

    // Mixed random traffic.
    for (int i = 0; i < 60; i++)
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            16'($urandom), 4'($urandom_range(0, 15)));
    for (int i = 0; i < 2; i++) cycle(1'b0, 2'd0, 16'h0000, 4'b1111);

    // Asynchronous reset mid-stream with channels 1 and 3 full.
    cycle(1'b1, 2'd1, 16'hAAAA, 4'b0000);
    cycle(1'b1, 2'd3, 16'hBBBB, 4'b0000);
    in_valid = 1'b1;
    sel      = 2'd1;
    in_data  = 16'hDEAD;
    in_ready = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 2'd1, 16'h5555, 4'b0000);
    cycle(1'b0, 2'd0, 16'h0000, 4'b0100);
    cycle(1'b0, 2'd0, 16'h0000, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
